// File: rtl/sd_cmd_arbiter_pkg.sv
// Shared SD command-path definitions: arbiter state encodings, the
// round-robin "last granted" encoding and the cmd_set field layout.
package sd_cmd_arbiter_pkg;

  // Arbiter FSM encodings (plain constants so legacy code can reuse them)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  // Encoding of the last_gnt bit used by the round-robin picker
  localparam logic LAST_HOST = 1'b0;
  localparam logic LAST_DATA = 1'b1;

  // cmd_set word layout: command index and response type
  localparam int CMD_IDX_MSB = 13;
  localparam int CMD_IDX_LSB = 8;
  localparam int CMD_RSP_MSB = 1;
  localparam int CMD_RSP_LSB = 0;

  // Extract the command index from a cmd_set word
  function automatic logic [5:0] cmd_index(input logic [15:0] cmd);
    return cmd[CMD_IDX_MSB:CMD_IDX_LSB];
  endfunction

  // Extract the response type from a cmd_set word
  function automatic logic [1:0] cmd_rsp_type(input logic [15:0] cmd);
    return cmd[CMD_RSP_MSB:CMD_RSP_LSB];
  endfunction

endpackage

// File: rtl/sd_rr_pick2.sv
// Two-way round-robin picker: a lone request always wins; on a tie the
// requester that was not granted last time wins.
module sd_rr_pick2
  import sd_cmd_arbiter_pkg::*;
(
  input  logic i_req_h,
  input  logic i_req_d,
  input  logic i_last_gnt,
  output logic o_pick_h,
  output logic o_pick_d
);

  // One-hot (or empty) pick from the two level requests
  always_comb begin
    o_pick_h = 1'b0;
    o_pick_d = 1'b0;
    if (i_req_h && i_req_d) begin
      if (i_last_gnt == LAST_DATA) begin
        o_pick_h = 1'b1;
      end else begin
        o_pick_d = 1'b1;
      end
    end else begin
      o_pick_h = i_req_h;
      o_pick_d = i_req_d;
    end
  end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// SD command arbiter: shares one command master between the host and the
// data engine. A granted command is issued with a one-cycle new_cmd_o
// pulse, the master must raise cicmd_i within START_TO cycles, then the
// command ends on cc_i (success) or ei_i (error). A one-cycle CLEAR state
// pulses done, err_o and both interrupt-clear strobes.
//
// Handshake: h_req_i/d_req_i are levels sampled only in IDLE; gnt is a
// level held from ISSUE through CLEAR; done is a single-cycle pulse in
// CLEAR and err_o is only non-zero alongside it. A requester that keeps
// its request high after done is served again as a new command.
module sd_cmd_arbiter
  import sd_cmd_arbiter_pkg::*;
#(
  parameter int START_TO = 16
) (
  input  logic        CLK_PAD_IO,
  input  logic        RST_PAD_I,
  input  logic        h_req_i,
  input  logic        d_req_i,
  input  logic [31:0] h_arg_i,
  input  logic [31:0] d_arg_i,
  input  logic [15:0] h_cmd_i,
  input  logic [15:0] d_cmd_i,
  output logic        h_gnt_o,
  output logic        d_gnt_o,
  output logic        h_done_o,
  output logic        d_done_o,
  output logic        err_o,
  output logic [31:0] resp_o,
  output logic        new_cmd_o,
  output logic [31:0] arg_o,
  output logic [15:0] cmd_set_o,
  input  logic        cicmd_i,
  input  logic        cc_i,
  input  logic        ei_i,
  input  logic [31:0] resp_i,
  output logic        normal_int_rst_o,
  output logic        err_int_rst_o
);

  localparam int CNT_W = $clog2(START_TO + 1);
  // The counter is cleared in ISSUE and reads k-1 in the k-th cycle after
  // new_cmd_o; leaving START on this value puts CLEAR (and done) exactly
  // START_TO cycles after new_cmd_o.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(START_TO - 2);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic             r_gnt_h;
  logic             r_gnt_d;
  logic             r_last_gnt;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_arg;
  logic [15:0]      r_cmd;
  logic [31:0]      r_resp;

  logic w_pick_h;
  logic w_pick_d;
  logic w_grant;
  logic w_set_err;
  logic w_cap_resp;
  logic w_timeout;
  logic w_in_clear;

  sd_rr_pick2 u_pick (
    .i_req_h    (h_req_i),
    .i_req_d    (d_req_i),
    .i_last_gnt (r_last_gnt),
    .o_pick_h   (w_pick_h),
    .o_pick_d   (w_pick_d)
  );

  assign w_timeout  = (r_cnt == TO_LAST);
  assign w_in_clear = (r_state == ST_CLEAR);

  // Next-state logic and the per-state side-effect strobes
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_set_err    = 1'b0;
    w_cap_resp   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (h_req_i || d_req_i) begin
          w_grant      = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_START;
      end
      ST_START: begin
        // cicmd_i in the last allowed cycle still counts as a start
        if (cicmd_i) begin
          w_state_next = ST_BUSY;
        end else if (w_timeout) begin
          w_set_err    = 1'b1;
          w_state_next = ST_CLEAR;
        end
      end
      ST_BUSY: begin
        // Error beats completion; the response is not taken on error
        if (ei_i) begin
          w_set_err    = 1'b1;
          w_state_next = ST_CLEAR;
        end else if (cc_i) begin
          w_cap_resp   = 1'b1;
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant levels and round-robin history; history starts at "data" so the
  // host wins the first tie
  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      r_gnt_h    <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_last_gnt <= LAST_DATA;
    end else if (w_grant) begin
      r_gnt_h <= w_pick_h;
      r_gnt_d <= w_pick_d;
    end else if (w_in_clear) begin
      r_gnt_h    <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_last_gnt <= r_gnt_d ? LAST_DATA : LAST_HOST;
    end
  end

  // Latch the winner's argument and command word; held until next grant
  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      r_arg <= '0;
      r_cmd <= '0;
    end else if (w_grant) begin
      r_arg <= w_pick_h ? h_arg_i : d_arg_i;
      r_cmd <= w_pick_h ? h_cmd_i : d_cmd_i;
    end
  end

  // Start-timeout counter: cleared on issue, counts while waiting for cicmd_i
  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      r_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Error flag for the command in flight
  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      r_err <= 1'b0;
    end else if (r_state == ST_ISSUE) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end
  end

  // Last successful response word
  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I) begin
    if (!RST_PAD_I) begin
      r_resp <= '0;
    end else if (w_cap_resp) begin
      r_resp <= resp_i;
    end
  end

  assign h_gnt_o          = r_gnt_h;
  assign d_gnt_o          = r_gnt_d;
  assign h_done_o         = w_in_clear & r_gnt_h;
  assign d_done_o         = w_in_clear & r_gnt_d;
  assign err_o            = w_in_clear & r_err;
  assign new_cmd_o        = (r_state == ST_ISSUE);
  assign normal_int_rst_o = w_in_clear;
  assign err_int_rst_o    = w_in_clear;
  assign arg_o            = r_arg;
  assign cmd_set_o        = r_cmd;
  assign resp_o           = r_resp;

endmodule
